// File: rtl/barrel_dispatcher.sv
// -----------------------------------------------------------------------------
// barrel_dispatcher
//
// Initiator side of the barrel launch interface. Decides when a barrel is
// thrown, picks a free mover slot round-robin, pulses that slot's launch
// line for PULSE_LEN cycles, and tracks each slot as busy until its mover
// reports done. After done, a slot sits in a short re-arm cooldown.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       game running; low stops new launches
//   done         per-slot completion level from the movers
//   barrel       per-slot launch pulse (registered, at most one bit high)
//   busy         per-slot "launched, not yet done" (registered)
//   throw        high exactly while any barrel bit is high
//   launch_count number of launches issued, wraps 255 -> 0
// -----------------------------------------------------------------------------
module barrel_dispatcher #(
    parameter int NUM_BARRELS  = 4,
    parameter int SPAWN_PERIOD = 130_000_000,
    parameter int PULSE_LEN    = 2,
    parameter int REARM_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_BARRELS-1:0] done,
    output logic [NUM_BARRELS-1:0] barrel,
    output logic [NUM_BARRELS-1:0] busy,
    output logic                   throw,
    output logic [7:0]             launch_count
);

    localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
    localparam int RR_W  = (NUM_BARRELS > 1) ? $clog2(NUM_BARRELS) : 1;

    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [3:0]             PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [3:0]             REARM_VAL  = 4'(REARM_CYCLES);
    localparam logic [RR_W-1:0]        RR_LAST    = RR_W'(NUM_BARRELS - 1);
    localparam logic [NUM_BARRELS-1:0] ONE_HOT0   = NUM_BARRELS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PEND,
        ST_LAUNCH
    } state_t;

    state_t                   state_reg,  state_next;
    logic [CNT_W-1:0]         cnt_reg,    cnt_next;
    logic [3:0]               pulse_reg,  pulse_next;
    logic [RR_W-1:0]          rr_reg,     rr_next;
    logic [NUM_BARRELS-1:0]   barrel_reg, barrel_next;
    logic [7:0]               count_reg,  count_next;
    logic                     stop_reg,   stop_next;
    logic [NUM_BARRELS-1:0]   busy_reg,   busy_next;
    logic [3:0]               cool_reg  [NUM_BARRELS];
    logic [3:0]               cool_next [NUM_BARRELS];

    logic [NUM_BARRELS-1:0]   slot_free;
    logic [NUM_BARRELS-1:0]   clear_hit;
    logic [NUM_BARRELS-1:0]   set_hit;
    logic                     any_free;
    logic [RR_W-1:0]          sel_idx;
    logic [RR_W-1:0]          cand;
    logic                     launch_go;

    // -------------------------------------------------------------------------
    // Per-slot bookkeeping. Completion only counts while the slot is busy, so
    // a done level held for several cycles is seen once. The launched slot is
    // always free (busy=0, cooldown=0), so set and clear never collide.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BARRELS; gi++) begin : g_slot
            assign slot_free[gi] = !busy_reg[gi] && (cool_reg[gi] == 4'd0);
            assign clear_hit[gi] = done[gi] && busy_reg[gi];
            assign set_hit[gi]   = launch_go && (sel_idx == RR_W'(gi));

            assign busy_next[gi] = clear_hit[gi] ? 1'b0 :
                                   set_hit[gi]   ? 1'b1 : busy_reg[gi];

            assign cool_next[gi] = clear_hit[gi]           ? REARM_VAL :
                                   (cool_reg[gi] != 4'd0)  ? cool_reg[gi] - 4'd1 :
                                                             cool_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin pick: first free slot at or after rr, wrapping. Iterating
    // downward lets the nearest candidate overwrite farther ones. Decisions
    // use registered status, so a slot freed at an edge is eligible from the
    // next decision onward.
    // -------------------------------------------------------------------------
    always_comb begin
        any_free = 1'b0;
        sel_idx  = '0;
        cand     = '0;
        for (int i = NUM_BARRELS - 1; i >= 0; i--) begin
            cand = RR_W'((int'(rr_reg) + i) % NUM_BARRELS);
            if (slot_free[cand]) begin
                any_free = 1'b1;
                sel_idx  = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Launch FSM: next state and datapath updates.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pulse_next  = pulse_reg;
        rr_next     = rr_reg;
        barrel_next = barrel_reg;
        count_next  = count_reg;
        stop_next   = stop_reg;
        launch_go   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    // Period expired: launch now or park until a slot frees.
                    if (any_free) begin
                        launch_go = 1'b1;
                    end else begin
                        state_next = ST_PEND;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_PEND: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (any_free) begin
                    launch_go = 1'b1;
                end
            end

            ST_LAUNCH: begin
                // The period counter keeps running through the pulse so that
                // launch-to-launch spacing is exactly SPAWN_PERIOD.
                cnt_next = cnt_reg + CNT_W'(1);
                // Remember an enable drop anywhere in the pulse; the pulse
                // itself always runs to full length.
                if (!enable) begin
                    stop_next = 1'b1;
                end
                if (pulse_reg == PULSE_LAST) begin
                    barrel_next = '0;
                    if (stop_reg || !enable) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else begin
                    pulse_next = pulse_reg + 4'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (launch_go) begin
            state_next  = ST_LAUNCH;
            cnt_next    = '0;
            pulse_next  = '0;
            stop_next   = 1'b0;
            barrel_next = ONE_HOT0 << sel_idx;
            count_next  = count_reg + 8'd1;
            rr_next     = (sel_idx == RR_LAST) ? '0 : sel_idx + RR_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            pulse_reg  <= '0;
            rr_reg     <= '0;
            barrel_reg <= '0;
            count_reg  <= '0;
            stop_reg   <= 1'b0;
            busy_reg   <= '0;
            for (int i = 0; i < NUM_BARRELS; i++) begin
                cool_reg[i] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pulse_reg  <= pulse_next;
            rr_reg     <= rr_next;
            barrel_reg <= barrel_next;
            count_reg  <= count_next;
            stop_reg   <= stop_next;
            busy_reg   <= busy_next;
            for (int i = 0; i < NUM_BARRELS; i++) begin
                cool_reg[i] <= cool_next[i];
            end
        end
    end

    assign barrel       = barrel_reg;
    assign busy         = busy_reg;
    assign throw        = |barrel_reg;
    assign launch_count = count_reg;

endmodule

// File: tb/tb_barrel_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_barrel_dispatcher
//
// Directed bench for barrel_dispatcher with NUM_BARRELS=4, SPAWN_PERIOD=8,
// PULSE_LEN=2, REARM_CYCLES=4. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point, so "value at edge E" means the
// registered value just after E.
// -----------------------------------------------------------------------------
module tb_barrel_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] done;
    logic [3:0] barrel;
    logic [3:0] busy;
    logic       throw;
    logic [7:0] launch_count;

    int vectors     = 0;
    int miscompares = 0;

    barrel_dispatcher #(
        .NUM_BARRELS (4),
        .SPAWN_PERIOD(8),
        .PULSE_LEN   (2),
        .REARM_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .done        (done),
        .barrel      (barrel),
        .busy        (busy),
        .throw       (throw),
        .launch_count(launch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        enable = 1'b0;
        done   = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b1;
        done   = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (barrel !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_barrel got %b want 0000", barrel);
        end
        vectors++;
        if (busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0000", busy);
        end
        vectors++;
        if (throw !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_throw got %b want 0", throw);
        end
        vectors++;
        if (launch_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d want 0", launch_count);
        end
        $display("reset: barrel=%b busy=%b throw=%b count=%0d", barrel, busy, throw, launch_count);
    endtask

    // Four launches 8 cycles apart, then all slots busy -> pend, then a
    // 3-cycle done on slot 2 frees it after the 4-cycle cooldown.
    task automatic test_basic_and_pend();
        logic [3:0] exp_b;
        logic [3:0] exp_busy;
        int         n;
        apply_reset();
        enable = 1'b1;
        tick();                                    // E0
        for (int t = 1; t <= 42; t++) begin
            tick();
            n        = (t / 8 > 4) ? 4 : t / 8;
            exp_b    = (t >= 8 && t <= 33 && (t % 8) < 2) ? 4'(1 << (t / 8 - 1)) : 4'b0000;
            exp_busy = 4'((1 << n) - 1);
            vectors++;
            if (barrel !== exp_b || throw !== (exp_b != 4'b0000)) begin
                miscompares++;
                $display("FAIL basic_barrel t=%0d got %b/%b want %b", t, barrel, throw, exp_b);
            end
            vectors++;
            if (busy !== exp_busy || launch_count !== 8'(n)) begin
                miscompares++;
                $display("FAIL basic_busy t=%0d got %b/%0d want %b/%0d", t, busy, launch_count, exp_busy, n);
            end
            if (exp_b != 4'b0000 && (t % 8) == 0)
                $display("basic: E0+%0d barrel=%b busy=%b count=%0d", t, barrel, busy, launch_count);
        end
        done = 4'b0100;
        for (int s = 0; s <= 4; s++) begin         // edges T .. T+4
            tick();
            if (s == 2) done = 4'b0000;
            vectors++;
            if (busy !== 4'b1011 || barrel !== 4'b0000 || launch_count !== 8'd4) begin
                miscompares++;
                $display("FAIL pend_hold T+%0d got busy=%b barrel=%b count=%0d want 1011/0000/4",
                         s, busy, barrel, launch_count);
            end
        end
        tick();                                    // T+5
        vectors++;
        if (barrel !== 4'b0100 || busy !== 4'b1111 || launch_count !== 8'd5) begin
            miscompares++;
            $display("FAIL pend_launch got barrel=%b busy=%b count=%0d want 0100/1111/5",
                     barrel, busy, launch_count);
        end
        $display("pend: T+5 barrel=%b busy=%b count=%0d", barrel, busy, launch_count);
        tick();                                    // T+6
        tick();                                    // T+7
        vectors++;
        if (barrel !== 4'b0000 || throw !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_fall got %b/%b want 0000/0", barrel, throw);
        end
    endtask

    // done on a slot that is not busy must not start a cooldown there.
    task automatic test_spurious_done();
        logic [3:0] exp_b;
        logic [3:0] exp_busy;
        logic [7:0] exp_cnt;
        apply_reset();
        done = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (busy !== 4'b0000 || launch_count !== 8'd0 || barrel !== 4'b0000) begin
                miscompares++;
                $display("FAIL spurious_idle got busy=%b count=%0d barrel=%b want 0000/0/0000",
                         busy, launch_count, barrel);
            end
        end
        enable = 1'b1;
        tick();                                    // E0
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 15) done = 4'b0000;
            exp_b    = (t == 8 || t == 9) ? 4'b0001 : (t == 16) ? 4'b0010 : 4'b0000;
            exp_busy = (t >= 16) ? 4'b0011 : (t >= 8) ? 4'b0001 : 4'b0000;
            exp_cnt  = (t >= 16) ? 8'd2 : (t >= 8) ? 8'd1 : 8'd0;
            vectors++;
            if (barrel !== exp_b || busy !== exp_busy || launch_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL spurious t=%0d got %b/%b/%0d want %b/%b/%0d",
                         t, barrel, busy, launch_count, exp_b, exp_busy, exp_cnt);
            end
        end
        $display("spurious: E0+16 barrel=%b busy=%b count=%0d", barrel, busy, launch_count);
    endtask

    // Drop enable mid-wait (counter=5) after one launch; re-enable resumes
    // from a cleared counter into slot rr=1.
    task automatic test_enable_drop();
        logic [3:0] exp_b;
        apply_reset();
        enable = 1'b1;
        tick();                                    // E0
        for (int t = 1; t <= 13; t++) begin
            tick();
            exp_b = (t == 8 || t == 9) ? 4'b0001 : 4'b0000;
            vectors++;
            if (barrel !== exp_b) begin
                miscompares++;
                $display("FAIL drop_pre t=%0d got %b want %b", t, barrel, exp_b);
            end
        end
        enable = 1'b0;
        for (int t = 14; t <= 33; t++) begin
            tick();
            vectors++;
            if (barrel !== 4'b0000 || throw !== 1'b0 || launch_count !== 8'd1) begin
                miscompares++;
                $display("FAIL drop_quiet t=%0d got %b/%b/%0d want 0000/0/1", t, barrel, throw, launch_count);
            end
        end
        enable = 1'b1;
        tick();                                    // E1
        for (int s = 1; s <= 8; s++) begin
            tick();
            exp_b = (s == 8) ? 4'b0010 : 4'b0000;
            vectors++;
            if (barrel !== exp_b) begin
                miscompares++;
                $display("FAIL drop_resume E1+%0d got %b want %b", s, barrel, exp_b);
            end
        end
        vectors++;
        if (launch_count !== 8'd2 || busy !== 4'b0011) begin
            miscompares++;
            $display("FAIL drop_resume_state got %0d/%b want 2/0011", launch_count, busy);
        end
        $display("enable_drop: E1+8 barrel=%b busy=%b count=%0d", barrel, busy, launch_count);
    endtask

    // enable low on the first pulse cycle: pulse still lasts 2 cycles, then idle.
    task automatic test_enable_pulse();
        logic [3:0] exp_b;
        apply_reset();
        enable = 1'b1;
        tick();                                    // E0
        for (int t = 1; t <= 8; t++) tick();
        enable = 1'b0;
        tick();                                    // E0+9
        vectors++;
        if (barrel !== 4'b0001 || throw !== 1'b1) begin
            miscompares++;
            $display("FAIL pulse_hold got %b/%b want 0001/1", barrel, throw);
        end
        for (int t = 10; t <= 29; t++) begin
            tick();
            vectors++;
            if (barrel !== 4'b0000 || launch_count !== 8'd1) begin
                miscompares++;
                $display("FAIL pulse_idle t=%0d got %b/%0d want 0000/1", t, barrel, launch_count);
            end
        end
        enable = 1'b1;
        tick();                                    // E2
        for (int s = 1; s <= 8; s++) begin
            tick();
            exp_b = (s == 8) ? 4'b0010 : 4'b0000;
            vectors++;
            if (barrel !== exp_b) begin
                miscompares++;
                $display("FAIL pulse_resume E2+%0d got %b want %b", s, barrel, exp_b);
            end
        end
        $display("enable_pulse: E2+8 barrel=%b count=%0d", barrel, launch_count);
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] exp_b;
        apply_reset();
        enable = 1'b1;
        tick();                                    // E0
        for (int t = 1; t <= 9; t++) tick();
        vectors++;
        if (barrel !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstpulse_pre got %b want 0001", barrel);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (barrel !== 4'b0000 || busy !== 4'b0000 || launch_count !== 8'd0 || throw !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpulse_clear got %b/%b/%0d/%b want 0000/0000/0/0",
                     barrel, busy, launch_count, throw);
        end
        rst = 1'b0;
        tick();                                    // new E0
        for (int s = 1; s <= 8; s++) begin
            tick();
            exp_b = (s == 8) ? 4'b0001 : 4'b0000;
            vectors++;
            if (barrel !== exp_b) begin
                miscompares++;
                $display("FAIL rstpulse_relaunch E0+%0d got %b want %b", s, barrel, exp_b);
            end
        end
        // Reset on the first pulse cycle must cut the pulse short.
        rst = 1'b1;
        tick();
        vectors++;
        if (barrel !== 4'b0000 || throw !== 1'b0 || busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstpulse_cut got %b/%b/%b want 0000/0/0000", barrel, throw, busy);
        end
        rst = 1'b0;
        $display("reset_mid_pulse: barrel=%b busy=%b count=%0d", barrel, busy, launch_count);
    endtask

    // done held high on every slot keeps them all cycling: 256 launches
    // rotate through slots 0..3 and the counter wraps to 0.
    task automatic test_wrap();
        logic [3:0] exp_b;
        apply_reset();
        done   = 4'b1111;
        enable = 1'b1;
        tick();                                    // E0
        for (int n = 1; n <= 256; n++) begin
            for (int c = 0; c < 8; c++) tick();
            exp_b = 4'(1 << ((n - 1) % 4));
            vectors++;
            if (barrel !== exp_b || busy !== exp_b || launch_count !== 8'(n)) begin
                miscompares++;
                $display("FAIL wrap n=%0d got %b/%b/%0d want %b/%b/%0d",
                         n, barrel, busy, launch_count, exp_b, exp_b, 8'(n));
            end
        end
        done = 4'b0000;
        $display("wrap: after 256 launches count=%0d", launch_count);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        done   = 4'b0000;
        test_reset();
        test_basic_and_pend();
        test_spurious_done();
        test_enable_drop();
        test_enable_pulse();
        test_reset_mid_pulse();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
